stream_packer: RTL

STREAM_PACKER -- requirements
Module: stream_packer

---
 rtl/stream_packer.sv | 88 ++++++++
 1 files changed

// File: rtl/stream_packer.sv
// Byte-to-word packer: collects up to OUT_BYTES bytes little-endian into one word,
// closing early on last_i, with a single-entry registered output stage.
module stream_packer #(
    parameter int OUT_BYTES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [7:0]             din,
    input  logic                   last_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [8*OUT_BYTES-1:0] dout,
    output logic [OUT_BYTES-1:0]   keep_o,
    output logic                   last_o,
    output logic [15:0]            word_cnt_o
);
    localparam int IW = $clog2(OUT_BYTES);

    logic [IW-1:0]               idx_q, idx_d;
    logic [OUT_BYTES-1:0][7:0]   acc_q, acc_d, word_d;
    logic [OUT_BYTES-1:0]        keep_d;
    logic [8*OUT_BYTES-1:0]      dout_q;
    logic [OUT_BYTES-1:0]        keep_q;
    logic                        valid_q, last_q;
    logic [15:0]                 cnt_q;
    logic                        in_acc, out_acc, close;

    assign ready_o    = !valid_q || ready_i;
    assign in_acc     = valid_i && ready_o;
    assign out_acc    = valid_q && ready_i;
    assign close      = in_acc && (last_i || (idx_q == IW'(OUT_BYTES - 1)));

    assign valid_o    = valid_q;
    assign dout       = dout_q;
    assign keep_o     = keep_q;
    assign last_o     = last_q;
    assign word_cnt_o = cnt_q;

    // Lanes above idx are already zero in the accumulator, since it is
    // cleared on every close and only ever written at lane idx.
    always_comb begin
        word_d = acc_q;
        keep_d = '0;
        for (int k = 0; k < OUT_BYTES; k++) begin
            if (IW'(k) == idx_q) word_d[k] = din;
            if (IW'(k) <= idx_q) keep_d[k] = 1'b1;
        end
        acc_d = acc_q;
        idx_d = idx_q;
        if (in_acc) begin
            if (close) begin
                acc_d = '0;
                idx_d = '0;
            end else begin
                acc_d = word_d;
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q   <= '0;
            acc_q   <= '0;
            dout_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            idx_q <= idx_d;
            acc_q <= acc_d;
            // A close in the same cycle as an output accept replaces the word
            // without a bubble.
            if (close) begin
                dout_q  <= word_d;
                keep_q  <= keep_d;
                last_q  <= last_i;
                valid_q <= 1'b1;
            end else if (out_acc) begin
                valid_q <= 1'b0;
            end
            if (out_acc) cnt_q <= cnt_q + 16'd1;
        end
    end
endmodule
